// File: rtl/display_pkg.sv
// Shared types and helpers for the 4-digit multiplexed display scanner.
package display_pkg;
  localparam int NDIG = 4;

  typedef logic [1:0] digit_t;
  typedef logic [3:0] nibble_t;

  // Digit index to active-low one-hot common-pin enable.
  function automatic logic [3:0] digit_en(digit_t d);
    return ~(4'b0001 << d);
  endfunction
endpackage

// File: rtl/scan_tick.sv
// Digit-dwell prescaler: counts 0..SCAN_DIV-1 and flags the last count as a 1-cycle tick.
module scan_tick #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/display_scan.sv
// 4-digit scan driver: frame-synchronous word update, registered num/ct outputs.
// DISPLAY_SCAN_LZB_EN enables leading-zero blanking of digits 1..3.
module display_scan
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  num,
  output logic [3:0]  ct,
  output logic        busy
);
  // load is a fire-and-forget strobe: no ready; busy only reports that a captured
  // word is waiting for the next frame boundary, and a newer load replaces it.
  logic        tick;
  digit_t      dig;
  digit_t      dig_next;
  logic [15:0] shadow;
  logic [15:0] pend_val;
  logic        pending;
  logic        boundary;
  logic [15:0] word_next;
  nibble_t     nib;
  logic        blank;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_comb begin
    boundary  = tick && (dig == digit_t'(NDIG - 1));
    word_next = shadow;
    // A load on the boundary cycle itself goes straight into the new frame.
    if (boundary) begin
      if (load) begin
        word_next = value;
      end else if (pending) begin
        word_next = pend_val;
      end
    end
    dig_next = dig + digit_t'(1);
    nib      = word_next[{dig_next, 2'b00} +: 4];
    blank    = 1'b0;
`ifdef DISPLAY_SCAN_LZB_EN
    blank = (dig_next != digit_t'(0)) && ((word_next >> {dig_next, 2'b00}) == 16'h0000);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig      <= '0;
      shadow   <= '0;
      pend_val <= '0;
      pending  <= 1'b0;
      num      <= 4'h0;
      ct       <= 4'b1110;
    end else begin
      if (boundary) begin
        shadow  <= word_next;
        pending <= 1'b0;
      end else if (load) begin
        pend_val <= value;
        pending  <= 1'b1;
      end
      if (tick) begin
        dig <= dig_next;
        num <= blank ? 4'h0 : nib;
        ct  <= blank ? 4'b1111 : digit_en(dig_next);
      end
    end
  end

  assign busy = pending;
endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan against a frame-level reference model.
module tb_display_scan;
  localparam int D     = 4;
  localparam int FRAME = 4 * D;
`ifdef DISPLAY_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  num;
  logic [3:0]  ct;
  logic        busy;

  always #5 clk = ~clk;

  display_scan #(.SCAN_DIV(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .value   (value),
    .num     (num),
    .ct      (ct),
    .busy    (busy)
  );

  // reference model state: edges since reset release and every load seen
  typedef struct {
    int          at;
    logic [15:0] val;
  } ld_t;
  ld_t ld_q[$];
  int  n = 0;
  int  cmp_count = 0;
  int  err_count = 0;
  logic [8:0] got;
  logic [8:0] exp_v;

  // Word shown in the frame starting at edge b: the latest load made at or before b.
  function automatic logic [15:0] frame_word(int b);
    logic [15:0] w = 16'h0000;
    foreach (ld_q[i]) if (ld_q[i].at <= b) w = ld_q[i].val;
    return w;
  endfunction

  // Expected {busy, ct, num} after edge n.
  function automatic logic [8:0] model_out();
    int          d = (n / D) % 4;
    int          b = (n / FRAME) * FRAME;
    logic [15:0] w = frame_word(b);
    logic        bz = 1'b0;
    logic [3:0]  c;
    logic [3:0]  nm;
    foreach (ld_q[i]) if (ld_q[i].at > b && ld_q[i].at <= n) bz = 1'b1;
    if (LZB && d > 0 && (w >> (4 * d)) == 16'h0000) begin
      c  = 4'b1111;
      nm = 4'h0;
    end else begin
      c  = 4'b1111 & ~(4'b0001 << d);
      nm = 4'((w >> (4 * d)) & 16'h000f);
    end
    return {bz, c, nm};
  endfunction

  // driver tasks
  task automatic step(input logic l, input logic [15:0] v);
    load  = l;
    value = v;
    @(posedge clk);
    #1;
    n++;
    if (l) ld_q.push_back('{n, v});
    load  = 1'b0;
  endtask

  task automatic align(input int m);
    while (n % FRAME != m) step(1'b0, 16'h0000);
  endtask

  task automatic run_checked(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(1'b0, 16'($urandom));
      got   = {busy, ct, num};
      exp_v = model_out();
      cmp_count++;
      if (got !== exp_v) begin
        err_count++;
        $display("FAIL %s n=%0d busy/ct/num got=%b expected=%b", name, n, got, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    value   = 16'($urandom);
    @(posedge clk);
    #1;
    got = {busy, ct, num};
    cmp_count++;
    if (got !== 9'b0_1110_0000) begin
      err_count++;
      $display("FAIL reset_values got=%b expected=%b", got, 9'b0_1110_0000);
    end
    reset_n = 1'b1;
    n = 0;
    ld_q.delete();
    run_checked("reset_scan", 2 * FRAME);
  endtask

  task automatic test_load_mid();
    align(6);
    step(1'b1, 16'h1234);
    got   = {busy, ct, num};
    exp_v = model_out();
    cmp_count++;
    if (got !== exp_v) begin
      err_count++;
      $display("FAIL load_mid_busy got=%b expected=%b", got, exp_v);
    end
    run_checked("load_mid", 2 * FRAME);
  endtask

  task automatic test_last_wins();
    logic seen_a = 1'b0;
    align(2);
    step(1'b1, 16'hAAAA);
    step(1'b0, 16'h0000);
    step(1'b1, 16'h5555);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 16'h0000);
      if (num == 4'hA) seen_a = 1'b1;
      got   = {busy, ct, num};
      exp_v = model_out();
      cmp_count++;
      if (got !== exp_v) begin
        err_count++;
        $display("FAIL last_wins n=%0d got=%b expected=%b", n, got, exp_v);
      end
    end
    cmp_count++;
    if (seen_a !== 1'b0) begin
      err_count++;
      $display("FAIL stale_aaaa_shown got=%b expected=0", seen_a);
    end
  endtask

  task automatic test_boundary_load();
    align(FRAME - 1);
    step(1'b1, 16'hBEEF);
    got = {busy, ct, num};
    cmp_count++;
    if (got !== 9'b0_1110_1111) begin
      err_count++;
      $display("FAIL boundary_bypass got=%b expected=%b", got, 9'b0_1110_1111);
    end
    run_checked("boundary_after", FRAME + 3);
  endtask

  task automatic test_reset_mid();
    align(0);
    step(1'b0, 16'h0000);
    step(1'b1, 16'h9876);
    while (n % FRAME != 9) step(1'b0, 16'h0000);
    got   = {busy, ct, num};
    exp_v = model_out();
    cmp_count++;
    if (got !== exp_v) begin
      err_count++;
      $display("FAIL pend_before_reset got=%b expected=%b", got, exp_v);
    end
    #2;
    reset_n = 1'b0;
    #1;
    got = {busy, ct, num};
    cmp_count++;
    if (got !== 9'b0_1110_0000) begin
      err_count++;
      $display("FAIL async_reset got=%b expected=%b", got, 9'b0_1110_0000);
    end
    reset_n = 1'b1;
    n = 0;
    ld_q.delete();
    run_checked("after_reset", 2 * FRAME);
  endtask

  task automatic test_lzb();
    align(5);
    step(1'b1, 16'h0042);
    run_checked("word_0042", 2 * FRAME);
    step(1'b1, 16'h0000);
    run_checked("word_0000", 2 * FRAME);
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      step($urandom_range(0, 7) == 0, v);
      got   = {busy, ct, num};
      exp_v = model_out();
      cmp_count++;
      if (got !== exp_v) begin
        err_count++;
        $display("FAIL random n=%0d got=%b expected=%b", n, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_mid();
    test_last_wins();
    test_boundary_load();
    test_reset_mid();
    test_lzb();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end
endmodule
